// File: rtl/prog_ctr.sv
// rtl/prog_ctr.sv - program counter and fetch sequencer (IDLE/RUN/HALTED)
module prog_ctr #(
    parameter int A  = 10,
    parameter int OW = 6,
    parameter int CW = 16
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          Start,
    input  logic [A-1:0]  StartAddr,
    input  logic          Halt,
    input  logic          Stall,
    input  logic          Jump,
    input  logic [A-1:0]  JumpTarget,
    input  logic          Branch,
    input  logic          Taken,
    input  logic [OW-1:0] Offset,
    output logic [A-1:0]  PC,
    output logic          Running,
    output logic          Done,
    output logic [CW-1:0] CycleCt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t        state;
    logic [A-1:0]  offset_ext;
    logic [CW-1:0] ct_next;

    // Sign-extend the relative branch offset to the PC width
    always_comb begin
        offset_ext = {{(A-OW){Offset[OW-1]}}, Offset};
    end

    // Saturating increment of the cycle counter
    always_comb begin
        ct_next = (CycleCt == {CW{1'b1}}) ? CycleCt : CycleCt + CW'(1);
    end

    // Status flags decode straight from the state register
    always_comb begin
        Running = (state == RUN);
        Done    = (state == HALTED);
    end

    // Sequencer: state, PC and cycle counter
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            PC      <= '0;
            CycleCt <= '0;
        end else begin
            case (state)
                IDLE, HALTED: begin
                    if (Start) begin
                        PC      <= StartAddr;
                        CycleCt <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    CycleCt <= ct_next;
                    if (Halt) begin
                        state <= HALTED;
                    end else if (Stall) begin
                        PC <= PC;
                    end else if (Jump) begin
                        PC <= JumpTarget;
                    end else if (Branch && Taken) begin
                        PC <= PC + offset_ext;
                    end else begin
                        PC <= PC + A'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_ctr.sv
// tb/tb_prog_ctr.sv - scoreboard testbench for prog_ctr
module tb_prog_ctr;

    localparam int A  = 10;
    localparam int OW = 6;
    localparam int CW = 6;

    logic          CLK;
    logic          Reset;
    logic          Start;
    logic [A-1:0]  StartAddr;
    logic          Halt;
    logic          Stall;
    logic          Jump;
    logic [A-1:0]  JumpTarget;
    logic          Branch;
    logic          Taken;
    logic [OW-1:0] Offset;
    logic [A-1:0]  PC;
    logic          Running;
    logic          Done;
    logic [CW-1:0] CycleCt;

    prog_ctr #(.A(A), .OW(OW), .CW(CW)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .Start      (Start),
        .StartAddr  (StartAddr),
        .Halt       (Halt),
        .Stall      (Stall),
        .Jump       (Jump),
        .JumpTarget (JumpTarget),
        .Branch     (Branch),
        .Taken      (Taken),
        .Offset     (Offset),
        .PC         (PC),
        .Running    (Running),
        .Done       (Done),
        .CycleCt    (CycleCt)
    );

    typedef struct {
        logic [A-1:0]  pc;
        logic          running;
        logic          done;
        logic [CW-1:0] ct;
    } exp_t;

    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;

    int            m_state;
    logic [A-1:0]  m_pc;
    logic [CW-1:0] m_ct;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_pc    = '0;
        m_ct    = '0;
    endtask

    // Drive one cycle of inputs, predict the result, then compare after the edge
    task automatic cyc(input logic st, input logic [A-1:0] sa, input logic h, input logic s,
                       input logic j, input logic [A-1:0] jt, input logic b, input logic t,
                       input logic [OW-1:0] off);
        exp_t e;
        Start = st; StartAddr = sa; Halt = h; Stall = s;
        Jump = j; JumpTarget = jt; Branch = b; Taken = t; Offset = off;
        case (m_state)
            1: begin
                if (m_ct != {CW{1'b1}}) m_ct = m_ct + 1'b1;
                if (h) m_state = 2;
                else if (s) m_pc = m_pc;
                else if (j) m_pc = jt;
                else if (b && t) m_pc = m_pc + {{(A-OW){off[OW-1]}}, off};
                else m_pc = m_pc + 1'b1;
            end
            default: begin
                if (st) begin
                    m_pc = sa; m_ct = '0; m_state = 1;
                end
            end
        endcase
        e.pc = m_pc; e.running = (m_state == 1); e.done = (m_state == 2); e.ct = m_ct;
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
        if (exp_q.size() == 0) begin
            chk("queue_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk("pc", 32'(PC), 32'(e.pc));
            chk("running", 32'(Running), 32'(e.running));
            chk("done", 32'(Done), 32'(e.done));
            chk("cycle_ct", 32'(CycleCt), 32'(e.ct));
        end
    endtask

    task automatic idle1();
        cyc(0, '0, 0, 0, 0, '0, 0, 0, '0);
    endtask

    initial begin
        Reset = 1'b1; Start = 0; StartAddr = '0; Halt = 0; Stall = 0;
        Jump = 0; JumpTarget = '0; Branch = 0; Taken = 0; Offset = '0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_pc", 32'(PC), 32'h0);
        chk("rst_running", 32'(Running), 32'h0);
        chk("rst_done", 32'(Done), 32'h0);
        chk("rst_ct", 32'(CycleCt), 32'h0);
        Reset = 1'b0;

        // Idle: unrelated controls ignored
        repeat (4) idle1();
        cyc(0, 10'h155, 1, 1, 1, 10'h2AA, 1, 1, 6'h01);

        // Straight-line run then halt
        cyc(1, 10'h010, 0, 0, 0, '0, 0, 0, '0);
        chk("start_pc", 32'(PC), 32'h010);
        repeat (3) idle1();
        cyc(1, 10'h3F0, 0, 0, 0, '0, 0, 0, '0);
        chk("straight_pc", 32'(PC), 32'h014);
        cyc(0, '0, 1, 0, 0, '0, 0, 0, '0);
        chk("straight_halt_pc", 32'(PC), 32'h014);
        chk("straight_done", 32'(Done), 32'h1);
        chk("straight_ct", 32'(CycleCt), 32'd5);
        cyc(0, '0, 1, 1, 1, 10'h123, 1, 1, 6'h05);
        idle1();

        // Restart from HALTED and redirects
        cyc(1, 10'h020, 0, 0, 0, '0, 0, 0, '0);
        chk("restart_ct", 32'(CycleCt), 32'd0);
        cyc(0, '0, 0, 0, 0, '0, 1, 1, 6'b111100);
        chk("branch_neg", 32'(PC), 32'h01C);
        cyc(0, '0, 0, 0, 0, '0, 1, 0, 6'b000111);
        chk("branch_not_taken", 32'(PC), 32'h01D);
        cyc(0, '0, 0, 0, 1, 10'h100, 1, 1, 6'b000111);
        chk("jump_over_branch", 32'(PC), 32'h100);
        cyc(0, '0, 0, 0, 0, '0, 1, 1, 6'b011111);

        // Wrap and priority
        cyc(0, '0, 0, 0, 1, 10'h3FF, 0, 0, '0);
        idle1();
        chk("wrap_inc", 32'(PC), 32'h000);
        cyc(0, '0, 0, 0, 1, 10'h002, 0, 0, '0);
        cyc(0, '0, 0, 0, 0, '0, 1, 1, 6'b111101);
        chk("wrap_branch", 32'(PC), 32'h3FF);
        cyc(0, '0, 0, 1, 1, 10'h0AA, 0, 0, '0);
        chk("stall_over_jump", 32'(PC), 32'h3FF);
        cyc(0, '0, 0, 0, 0, '0, 1, 1, 6'b000000);
        chk("spin_loop", 32'(PC), 32'h3FF);
        cyc(0, '0, 1, 1, 1, 10'h0AA, 0, 0, '0);
        chk("halt_over_stall", 32'(Done), 32'h1);
        cyc(1, 10'h040, 0, 0, 0, '0, 0, 0, '0);
        chk("restart_pc", 32'(PC), 32'h040);
        chk("restart_running", 32'(Running), 32'h1);

        // Saturation of the cycle counter
        for (int i = 0; i < 70; i++) cyc(0, '0, 0, (i % 2) == 0, 0, '0, 0, 0, '0);
        chk("ct_saturate", 32'(CycleCt), 32'(2**CW - 1));

        // Asynchronous reset mid-cycle in RUN
        #3;
        Reset = 1'b1;
        #1;
        chk("async_pc", 32'(PC), 32'h0);
        chk("async_running", 32'(Running), 32'h0);
        chk("async_ct", 32'(CycleCt), 32'h0);
        model_reset();
        @(posedge CLK);
        #1;
        Reset = 1'b0;
        repeat (2) idle1();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
